// File: rtl/wb_bypass_sched.sv
// Round-robin writeback port arbiter with a DEPTH-deep bypass window.
// At most one valid window entry exists per register index at any time.
module wb_bypass_sched #(
  parameter int NUM_REQ  = 4,
  parameter int DEPTH    = 4,
  parameter int IDXWIDTH = $clog2(128),
  parameter int DWIDTH   = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic [NUM_REQ-1:0]           i_req_vld,
  output logic [NUM_REQ-1:0]           o_req_rdy,
  input  logic [NUM_REQ*IDXWIDTH-1:0]  i_req_idx,
  input  logic [NUM_REQ*DWIDTH-1:0]    i_req_data,
  output logic                         o_wb_vld,
  output logic [IDXWIDTH-1:0]          o_wb_idx,
  output logic [DWIDTH-1:0]            o_wb_data,
  output logic [DEPTH-1:0]             o_byp_vld,
  output logic [DEPTH*IDXWIDTH-1:0]    o_byp_idx,
  output logic [DEPTH*DWIDTH-1:0]      o_byp_data
);

  localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTRW-1:0]     ptr;
  logic [PTRW-1:0]     gnt;
  logic [PTRW-1:0]     ptr_nxt;
  logic                gnt_vld;
  logic                fire;
  logic [IDXWIDTH-1:0] sel_idx;
  logic [DWIDTH-1:0]   sel_data;
  logic [DEPTH-1:0]    win_vld;
  logic [IDXWIDTH-1:0] win_idx  [DEPTH];
  logic [DWIDTH-1:0]   win_data [DEPTH];

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    int k;
    gnt     = '0;
    gnt_vld = 1'b0;
    k       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (i_req_vld[k[PTRW-1:0]]) begin
        gnt     = k[PTRW-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    o_req_rdy = '0;
    if (gnt_vld && !i_flush && rst_n) o_req_rdy[gnt] = 1'b1;
  end

  assign fire    = |(i_req_vld & o_req_rdy);
  assign ptr_nxt = (gnt == PTRW'(NUM_REQ - 1)) ? '0 : gnt + PTRW'(1);

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt == PTRW'(k)) begin
        sel_idx  = i_req_idx[k*IDXWIDTH +: IDXWIDTH];
        sel_data = i_req_data[k*DWIDTH +: DWIDTH];
      end
    end
  end

  // Entry 0 is the writeback itself; older entries carrying the new index are retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      win_vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        win_idx[k]  <= '0;
        win_data[k] <= '0;
      end
    end else begin
      if (fire) begin
        ptr         <= ptr_nxt;
        win_idx[0]  <= sel_idx;
        win_data[0] <= sel_data;
      end
      win_vld[0] <= fire;
      for (int k = 1; k < DEPTH; k++) begin
        win_vld[k]  <= win_vld[k-1] && !i_flush &&
                       !(fire && (win_idx[k-1] == sel_idx));
        win_idx[k]  <= win_idx[k-1];
        win_data[k] <= win_data[k-1];
      end
    end
  end

  always_comb begin
    o_byp_vld = win_vld;
    for (int k = 0; k < DEPTH; k++) begin
      o_byp_idx[k*IDXWIDTH +: IDXWIDTH] = win_idx[k];
      o_byp_data[k*DWIDTH +: DWIDTH]    = win_data[k];
    end
  end

  assign o_wb_vld  = win_vld[0];
  assign o_wb_idx  = win_idx[0];
  assign o_wb_data = win_data[0];

endmodule
